io_input_conditioner: RTL

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

---
 rtl/io_input_conditioner.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/io_input_conditioner.sv
// Conditions raw board inputs: two-flop synchronizers, per-button debounce FSMs
// producing one-cycle press pulses, and a shared-counter switch debouncer.
`timescale 1ns/1ps
module io_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_WIDTH        = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          buttons_n,
    input  logic [SW_WIDTH-1:0] switches_raw,
    output logic [1:0]          inport_en,
    output logic [1:0]          buttons_held,
    output logic [SW_WIDTH-1:0] switches_out
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_e;

    logic [1:0]          btn_s1_q, btn_s2_q;
    logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q, sw_prev_q, switches_out_q;
    logic [CNT_W-1:0]    sw_cnt_q, sw_cnt_d;
    logic                sw_stable, sw_load;

    // Synchronizers reset to "released" so a held button is re-debounced after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q <= 2'b11;
            btn_s2_q <= 2'b11;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= buttons_n;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= switches_raw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_state_e       state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             pressed, pulse_d, held, en_q;

            assign pressed = ~btn_s2_q[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    en_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    en_q    <= pulse_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    IDLE: begin
                        if (pressed) begin
                            state_d = PRESS_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!pressed) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!pressed) begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (pressed) begin
                            state_d = HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            always_comb begin
                pulse_d = (state_q == PRESS_WAIT) && (state_d == HELD);
                held    = (state_q == HELD) || (state_q == RELEASE_WAIT);
            end

            assign inport_en[gi]    = en_q;
            assign buttons_held[gi] = held;
        end
    endgenerate

    // Loading on the edge the counter reaches its terminal value makes the output
    // follow DEBOUNCE_CYCLES equal consecutive synchronized samples.
    always_comb begin
        sw_stable = (sw_s2_q == sw_prev_q);
        sw_load   = sw_stable && (sw_cnt_q >= CNT_LOAD);
        if (!sw_stable) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q == CNT_LAST) begin
            sw_cnt_d = sw_cnt_q;
        end else begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_prev_q      <= '0;
            sw_cnt_q       <= '0;
            switches_out_q <= '0;
        end else begin
            sw_prev_q <= sw_s2_q;
            sw_cnt_q  <= sw_cnt_d;
            if (sw_load) begin
                switches_out_q <= sw_s2_q;
            end
        end
    end

    assign switches_out = switches_out_q;
endmodule
